reflet_align_ctrl: RTL and testbench

REFLET_ALIGN_CTRL -- requirements
Module: reflet_align_ctrl

---
 rtl/reflet_align_ctrl_pkg.sv | 11 +
 rtl/reflet_align_merge.sv | 22 ++
 rtl/reflet_align_ctrl.sv | 113 +++++++++++
 tb/tb_reflet_align_ctrl.sv | 136 +++++++++++++
 4 files changed

// File: rtl/reflet_align_ctrl_pkg.sv
// reflet_align_ctrl_pkg: controller state encoding and byte-lane geometry helpers
package reflet_align_ctrl_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_RDW, S_WR0, S_WR1, S_ACK} state_t;
  localparam int BYTE_W = 8;
  function automatic int align_nb(input int w);
    return w / BYTE_W;
  endfunction
  function automatic int align_ob(input int w);
    return $clog2(w / BYTE_W);
  endfunction
endpackage

// File: rtl/reflet_align_merge.sv
// reflet_align_merge: byte-granular extract/insert across a two-word little-endian window
module reflet_align_merge
  import reflet_align_ctrl_pkg::*;
#(
  parameter int W  = 32,
  parameter int OB = align_ob(W)
) (
  input  logic [W-1:0]  w0,
  input  logic [W-1:0]  w1,
  input  logic [OB-1:0] off,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [W-1:0]  m0,
  output logic [W-1:0]  m1
);
  logic [2*W-1:0] cat, ins, mask;
  assign cat   = {w1, w0};
  assign rdata = W'(cat >> {off, 3'b000});
  assign ins   = {{W{1'b0}}, wdata} << {off, 3'b000};
  assign mask  = {{W{1'b0}}, {W{1'b1}}} << {off, 3'b000};
  assign {m1, m0} = (cat & ~mask) | (ins & mask);
endmodule

// File: rtl/reflet_align_ctrl.sv
// reflet_align_ctrl: splits unaligned CPU accesses into word reads/read-modify-writes
module reflet_align_ctrl
  import reflet_align_ctrl_pkg::*;
#(
  parameter int wordsize = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [wordsize-1:0] cpu_addr,
  input  logic [wordsize-1:0] cpu_data_out,
  input  logic                cpu_write_en,
  input  logic                cpu_read_en,
  output logic [wordsize-1:0] cpu_data_in,
  output logic                cpu_ack,
  output logic                busy,
  output logic [wordsize-1:0] mem_addr,
  output logic [wordsize-1:0] mem_data_out,
  output logic                mem_write_en,
  input  logic [wordsize-1:0] mem_data_in
);
  localparam int OB = align_ob(wordsize);
  localparam int AW = wordsize - OB;
  state_t state_q, state_d;
  logic [wordsize-1:0] addr_q, addr_d, wdata_q, wdata_d, w0_q, w0_d, w1_q, w1_d;
  logic                wr_q, wr_d, mis_q, mis_d;
  logic [wordsize-1:0] rdata, m0, m1;
  logic [AW-1:0]       a0;
  logic [wordsize-1:0] mem_addr_q, mem_addr_d, mem_data_out_q, mem_data_out_d;
  logic [wordsize-1:0] cpu_data_in_q, cpu_data_in_d;
  logic                mem_write_en_q, cpu_ack_q, busy_q;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    w0_d    = w0_q;
    w1_d    = w1_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: if (cpu_write_en || cpu_read_en) begin
        addr_d  = cpu_addr;
        wdata_d = cpu_data_out;
        wr_d    = cpu_write_en;
        mis_d   = cpu_addr[OB-1:0] != '0;
        w0_d    = '0;
        w1_d    = '0;
        state_d = (cpu_write_en && cpu_addr[OB-1:0] == '0) ? S_WR0 : S_RD0;
      end
      S_RD0: state_d = mis_q ? S_RD1 : S_RDW;
      S_RD1: begin
        w0_d    = mem_data_in;
        state_d = S_RDW;
      end
      S_RDW: begin
        w0_d    = mis_q ? w0_q : mem_data_in;
        w1_d    = mis_q ? mem_data_in : w1_q;
        state_d = wr_q ? S_WR0 : S_ACK;
      end
      S_WR0:   state_d = mis_q ? S_WR1 : S_ACK;
      S_WR1:   state_d = S_ACK;
      default: state_d = S_IDLE;
    endcase
  end
  // merge sees next-state words so the capture edge and the use edge can coincide
  reflet_align_merge #(.W(wordsize), .OB(OB)) u_merge (
    .w0(w0_d), .w1(w1_d), .off(addr_d[OB-1:0]), .wdata(wdata_d),
    .rdata(rdata), .m0(m0), .m1(m1)
  );
  always_comb begin
    a0             = addr_d[wordsize-1:OB];
    mem_addr_d     = (state_d == S_RD0 || state_d == S_WR0) ? {{OB{1'b0}}, a0} :
                     (state_d == S_RD1 || state_d == S_WR1) ? {{OB{1'b0}}, a0 + AW'(1)} : '0;
    mem_data_out_d = (state_d == S_WR0) ? m0 : (state_d == S_WR1) ? m1 : '0;
    cpu_data_in_d  = (state_d == S_ACK && !wr_d) ? rdata : '0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      w0_q           <= '0;
      w1_q           <= '0;
      wr_q           <= 1'b0;
      mis_q          <= 1'b0;
      mem_addr_q     <= '0;
      mem_data_out_q <= '0;
      cpu_data_in_q  <= '0;
      mem_write_en_q <= 1'b0;
      cpu_ack_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      w0_q           <= w0_d;
      w1_q           <= w1_d;
      wr_q           <= wr_d;
      mis_q          <= mis_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_out_q <= mem_data_out_d;
      cpu_data_in_q  <= cpu_data_in_d;
      mem_write_en_q <= state_d == S_WR0 || state_d == S_WR1;
      cpu_ack_q      <= state_d == S_ACK;
      busy_q         <= state_d != S_IDLE;
    end
  end
  assign mem_addr     = mem_addr_q;
  assign mem_data_out = mem_data_out_q;
  assign mem_write_en = mem_write_en_q;
  assign cpu_data_in  = cpu_data_in_q;
  assign cpu_ack      = cpu_ack_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_reflet_align_ctrl.sv
// tb_reflet_align_ctrl: directed checks of reflet_align_ctrl against a 1-cycle RAM
module tb_reflet_align_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_data_out, cpu_data_in, mem_addr, mem_data_out, mem_data_in;
  logic        cpu_write_en, cpu_read_en, cpu_ack, busy, mem_write_en;
  logic [31:0] mem [0:1023];
  logic [31:0] addrs [0:12];
  int          nwr = 0;
  int          total = 0, passed = 0, fails = 0;
  int          ack_at, nw0, hits;
  logic [31:0] rd, prev257;
  logic        busy_at_ack;

  reflet_align_ctrl #(.wordsize(32)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
    .cpu_write_en(cpu_write_en), .cpu_read_en(cpu_read_en), .cpu_data_in(cpu_data_in),
    .cpu_ack(cpu_ack), .busy(busy), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_write_en(mem_write_en), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_addr[9:0]] <= mem_data_out;
      nwr <= nwr + 1;
    end
    mem_data_in <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re);
    cpu_addr = a; cpu_data_out = d; cpu_write_en = we; cpu_read_en = re;
    ack_at = -1; rd = '0; busy_at_ack = 1'b0;
    for (int i = 0; i <= 12; i++) addrs[i] = 'x;
    for (int e = 1; e <= 12 && ack_at < 0; e++) begin
      @(posedge clk); #1;
      addrs[e] = mem_addr;
      if (cpu_ack) begin
        ack_at = e; rd = cpu_data_in; busy_at_ack = busy;
        cpu_write_en = 1'b0; cpu_read_en = 1'b0;
      end
    end
    cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[256] = 32'hABCDEF00;
    mem[257] = 32'h01020304;
    reset = 1'b0; cpu_addr = '0; cpu_data_out = '0; cpu_write_en = 1'b0; cpu_read_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ack", {31'b0, cpu_ack}, 32'h0);
    chk("rst_mwe", {31'b0, mem_write_en}, 32'h0);
    chk("rst_maddr", mem_addr, 32'h0);
    chk("rst_mdata", mem_data_out, 32'h0);
    chk("rst_rdata", cpu_data_in, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    run_op(32'h400, 32'h0, 1'b0, 1'b1);
    hits = 0;
    for (int e = 1; e <= 3; e++) if (addrs[e] === 32'h100) hits++;
    chk("ard_ack_edge", ack_at, 3);
    chk("ard_data", rd, 32'hABCDEF00);
    chk("ard_addr0", addrs[1], 32'h100);
    chk("ard_addr_once", hits, 1);
    chk("ard_busy_in_ack", {31'b0, busy_at_ack}, 32'h1);

    run_op(32'h401, 32'h0, 1'b0, 1'b1);
    chk("mrd_ack_edge", ack_at, 4);
    chk("mrd_data", rd, 32'h04ABCDEF);
    chk("mrd_addr0", addrs[1], 32'h100);
    chk("mrd_addr1", addrs[2], 32'h101);

    nw0 = nwr;
    run_op(32'h402, 32'h11223344, 1'b1, 1'b0);
    chk("mwr_ack_edge", ack_at, 6);
    chk("mwr_nwrites", nwr - nw0, 2);
    chk("mwr_w256", mem[256], 32'h3344EF00);
    chk("mwr_w257", mem[257], 32'h01021122);
    chk("mwr_rdata_zero", rd, 32'h0);

    run_op(32'hFFFFFFFD, 32'h0, 1'b0, 1'b1);
    chk("wrap_ack_edge", ack_at, 4);
    chk("wrap_addr0", addrs[1], 32'h3FFFFFFF);
    chk("wrap_addr1", addrs[2], 32'h00000000);

    nw0 = nwr;
    run_op(32'h404, 32'hDEADBEEF, 1'b1, 1'b1);
    chk("both_ack_edge", ack_at, 2);
    chk("both_nwrites", nwr - nw0, 1);
    chk("both_w257", mem[257], 32'hDEADBEEF);
    chk("both_w256", mem[256], 32'h3344EF00);

    // misaligned write spanning 256/257, reset asserted during its WR1 cycle
    prev257 = mem[257];
    nw0 = nwr;
    cpu_addr = 32'h403; cpu_data_out = 32'h99887766; cpu_write_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    cpu_write_en = 1'b0;
    chk("abort_pre_mwe", {31'b0, mem_write_en}, 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_mwe", {31'b0, mem_write_en}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_maddr", mem_addr, 32'h0);
    @(posedge clk); #1;
    chk("abort_w257", mem[257], prev257);
    chk("abort_w256", mem[256], 32'h6644EF00);
    chk("abort_nwrites", nwr - nw0, 1);
    reset = 1'b1;
    hits = 0;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk); #1;
      if (cpu_ack || busy) hits++;
    end
    chk("abort_no_ack", hits, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
